// File: rtl/ulpb_tx_sequencer_if.sv
// Host-side word stream into the ULPB TX sequencer.
// The host drives words; the sequencer answers with IN_READY.
interface ulpb_tx_sequencer_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_ADDR;
  logic        IN_PRIORITY;
  logic [31:0] IN_DATA;
  logic        IN_LAST;

  modport master (
    output IN_VALID, IN_ADDR, IN_PRIORITY,
    output IN_DATA, IN_LAST,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID, IN_ADDR, IN_PRIORITY,
    input  IN_DATA, IN_LAST,
    output IN_READY
  );
endinterface

// File: rtl/ulpb_tx_sequencer.sv
// Store-and-forward message sequencer from a host word FIFO
// onto the ULPB node TX handshake, with retry and drop.
module ulpb_tx_sequencer #(
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               resetn,
  ulpb_tx_sequencer_if.slave in_if,
  output logic [7:0]         TX_ADDR,
  output logic [31:0]        TX_DATA,
  output logic               TX_REQ,
  input  logic               TX_ACK,
  output logic               TX_PEND,
  output logic               PRIORITY,
  input  logic               TX_SUCC,
  input  logic               TX_FAIL,
  output logic               TX_RESP_ACK,
  output logic               MSG_DONE,
  output logic               MSG_DROP,
  output logic               ERR_LEN,
  output logic               BUSY
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [7:0]    RMAX = 8'(MAX_RETRY);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ_HI    = 3'd1;
  localparam logic [2:0] S_REQ_LO    = 3'd2;
  localparam logic [2:0] S_RESP_WAIT = 3'd3;
  localparam logic [2:0] S_RESP_ACK  = 3'd4;

  logic [31:0] mdat_q  [DEPTH];
  logic        mlast_q [DEPTH];
  logic [7:0]  maddr_q [DEPTH];
  logic        mprio_q [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] mcnt_q, mcnt_d;
  logic [7:0]    retry_q, retry_d;
  logic          first_q, first_d;
  logic [7:0]    haddr_q, haddr_d;
  logic          hprio_q, hprio_d;
  logic          disc_q, disc_d;
  logic          rdy_q;
  logic          fail_q, fail_d;
  logic          seen_q, seen_d;
  logic          req_q, req_d;
  logic          pend_q, pend_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    addr_q, addr_d;
  logic          prio_q, prio_d;
  logic          rack_q, rack_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;

  logic [PW-1:0] occ;
  logic          push, wr, flush, rslt, inc, dec;
  logic [7:0]    waddr;
  logic          wprio;
  logic [AW-1:0] ridx, cidx, widx;

  // Occupancy is measured from the commit pointer so a
  // message stays resident until the node has accepted it.
  assign occ   = wptr_q - cptr_q;
  assign in_if.IN_READY = rdy_q & (disc_q | (occ != FULL));
  assign push  = in_if.IN_VALID & in_if.IN_READY;
  assign wr    = push & ~disc_q;
  assign flush = (occ == FULL) & (mcnt_q == '0);
  assign rslt  = TX_SUCC | TX_FAIL;
  assign inc   = wr & in_if.IN_LAST;
  assign waddr = first_q ? in_if.IN_ADDR : haddr_q;
  assign wprio = first_q ? in_if.IN_PRIORITY : hprio_q;
  assign ridx  = rptr_q[AW-1:0];
  assign cidx  = cptr_q[AW-1:0];
  assign widx  = wptr_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr) begin
      mdat_q[widx]  <= in_if.IN_DATA;
      mlast_q[widx] <= in_if.IN_LAST;
      maddr_q[widx] <= waddr;
      mprio_q[widx] <= wprio;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cptr_d  = cptr_q;
    retry_d = retry_q;
    first_d = first_q;
    haddr_d = haddr_q;
    hprio_d = hprio_q;
    disc_d  = disc_q;
    fail_d  = fail_q;
    seen_d  = seen_q;
    req_d   = req_q;
    pend_d  = pend_q;
    data_d  = data_q;
    addr_d  = addr_q;
    prio_d  = prio_q;
    rack_d  = rack_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    dec     = 1'b0;

    if (wr) begin
      wptr_d  = wptr_q + 1'b1;
      first_d = in_if.IN_LAST;
      haddr_d = waddr;
      hprio_d = wprio;
    end
    if (push & disc_q & in_if.IN_LAST) begin
      disc_d  = 1'b0;
      first_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          wptr_d = '0;
          rptr_d = '0;
          cptr_d = '0;
          disc_d = 1'b1;
          err_d  = 1'b1;
        end else if (mcnt_q != '0) begin
          rptr_d  = cptr_q;
          addr_d  = maddr_q[cidx];
          prio_d  = mprio_q[cidx];
          data_d  = mdat_q[cidx];
          pend_d  = ~mlast_q[cidx];
          req_d   = 1'b1;
          fail_d  = 1'b0;
          seen_d  = 1'b0;
          state_d = S_REQ_HI;
        end
      end
      S_REQ_HI: begin
        if (rslt) begin
          req_d   = 1'b0;
          rack_d  = 1'b1;
          fail_d  = TX_FAIL;
          state_d = S_RESP_ACK;
        end else if (TX_ACK) begin
          req_d   = 1'b0;
          rptr_d  = rptr_q + 1'b1;
          seen_d  = mlast_q[ridx];
          state_d = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (rslt) begin
          rack_d  = 1'b1;
          fail_d  = TX_FAIL;
          state_d = S_RESP_ACK;
        end else if (!TX_ACK) begin
          if (pend_q) begin
            data_d  = mdat_q[ridx];
            pend_d  = ~mlast_q[ridx];
            req_d   = 1'b1;
            state_d = S_REQ_HI;
          end else begin
            state_d = S_RESP_WAIT;
          end
        end
      end
      S_RESP_WAIT: begin
        if (rslt) begin
          rack_d  = 1'b1;
          fail_d  = TX_FAIL;
          state_d = S_RESP_ACK;
        end
      end
      S_RESP_ACK: begin
        fail_d = fail_q | TX_FAIL;
        // Early result: walk rptr to the message end first.
        if (!seen_q) begin
          rptr_d = rptr_q + 1'b1;
          seen_d = mlast_q[ridx];
        end else if (!rslt) begin
          rack_d  = 1'b0;
          state_d = S_IDLE;
          if (!fail_q) begin
            cptr_d  = rptr_q;
            retry_d = '0;
            done_d  = 1'b1;
            dec     = 1'b1;
          end else if (retry_q < RMAX) begin
            retry_d = retry_q + 1'b1;
          end else begin
            cptr_d  = rptr_q;
            retry_d = '0;
            drop_d  = 1'b1;
            dec     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mcnt_d = mcnt_q + PW'(inc) - PW'(dec);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cptr_q  <= '0;
      mcnt_q  <= '0;
      retry_q <= '0;
      first_q <= 1'b1;
      haddr_q <= '0;
      hprio_q <= 1'b0;
      disc_q  <= 1'b0;
      rdy_q   <= 1'b0;
      fail_q  <= 1'b0;
      seen_q  <= 1'b0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      prio_q  <= 1'b0;
      rack_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cptr_q  <= cptr_d;
      mcnt_q  <= mcnt_d;
      retry_q <= retry_d;
      first_q <= first_d;
      haddr_q <= haddr_d;
      hprio_q <= hprio_d;
      disc_q  <= disc_d;
      rdy_q   <= 1'b1;
      fail_q  <= fail_d;
      seen_q  <= seen_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      prio_q  <= prio_d;
      rack_q  <= rack_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign TX_ADDR     = addr_q;
  assign TX_DATA     = data_q;
  assign TX_REQ      = req_q;
  assign TX_PEND     = pend_q;
  assign PRIORITY    = prio_q;
  assign TX_RESP_ACK = rack_q;
  assign MSG_DONE    = done_q;
  assign MSG_DROP    = drop_q;
  assign ERR_LEN     = err_q;
  assign BUSY        = (state_q != S_IDLE);
endmodule
